// File: rtl/cpu_div_pkg.sv
// rtl/cpu_div_pkg.sv - shared state encoding and constants for the sequential divider
package cpu_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITER,
        FIXUP,
        DONE
    } div_state_t;

    // Wide enough for the largest supported operand; sliced down to WIDTH at use.
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

    function automatic int div_cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_shift,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // rem_shift < 2*divisor always holds, so a non-negative difference fits in WIDTH bits.
    assign diff     = rem_shift - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring signed/unsigned integer divider
module seq_divider
    import cpu_div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit SIGNED_DEFAULT = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = div_cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] rem_r;
    logic             mode_r;
    logic             q_neg;
    logic             r_neg;
    logic             dz_r;
    logic             ov_r;

    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    assign dvd_neg = mode_r & dvd_r[WIDTH-1];
    assign dsr_neg = mode_r & dsr_r[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dvd_r : dvd_r;
    assign dsr_mag = dsr_neg ? -dsr_r : dsr_r;

    // dvd_r doubles as the dividend shift register and the quotient accumulator.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_shift (Ffwd(rem_r, dvd_r[WIDTH-1])),
        .divisor   (dsr_r),
        .rem_next  (rem_next),
        .q_bit     (q_bit)
    );

    function automatic logic [WIDTH:0] Ffwd(input logic [WIDTH-1:0] rem, input logic in_bit);
        return {rem, in_bit};
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            cnt_r       <= '0;
            dvd_r       <= '0;
            dsr_r       <= '0;
            rem_r       <= '0;
            mode_r      <= SIGNED_DEFAULT;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz_r        <= 1'b0;
            ov_r        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r       <= dividend;
                        dsr_r       <= divisor;
                        mode_r      <= signed_mode;
                        dz_r        <= 1'b0;
                        ov_r        <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (dsr_r == '0) begin
                        dvd_r <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                        rem_r <= dvd_r;
                        dz_r  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (mode_r && dvd_r == MIN_VAL && dsr_r == '1) begin
                        rem_r <= '0;
                        ov_r  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        dvd_r <= dvd_mag;
                        dsr_r <= dsr_mag;
                        rem_r <= '0;
                        q_neg <= dvd_neg ^ dsr_neg;
                        r_neg <= dvd_neg;
                        cnt_r <= CW'(WIDTH - 1);
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem_r <= rem_next;
                    dvd_r <= {dvd_r[WIDTH-2:0], q_bit};
                    if (cnt_r == '0) begin
                        state <= FIXUP;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                FIXUP: begin
                    if (q_neg) begin
                        dvd_r <= -dvd_r;
                    end
                    if (r_neg) begin
                        rem_r <= -rem_r;
                    end
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    done        <= 1'b1;
                    quotient    <= dvd_r;
                    remainder   <= rem_r;
                    div_by_zero <= dz_r;
                    overflow    <= ov_r;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider with directed vectors
module tb_seq_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
        int           t0;
    } exp_t;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    seq_divider #(.WIDTH(W), .SIGNED_DEFAULT(1'b1)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    // Monitor: every done strobe is matched against the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!clear) begin
            if (busy && done) begin
                n_cmp = n_cmp + 1;
                n_err = n_err + 1;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both 1", busy, done);
            end
            if (done) begin
                n_cmp = n_cmp + 1;
                if (exp_q.size() == 0) begin
                    n_err = n_err + 1;
                    $display("FAIL unexpected_done: q=%h r=%h, required no done", quotient, remainder);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
                        n_err = n_err + 1;
                        $display("FAIL result: got q=%h r=%h dz=%0b ov=%0b, required q=%h r=%h dz=%0b ov=%0b",
                                 quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dz, e.ov);
                    end
                    n_cmp = n_cmp + 1;
                    if (cyc - e.t0 != e.lat) begin
                        n_err = n_err + 1;
                        $display("FAIL latency: got %0d cycles, required %0d", cyc - e.t0, e.lat);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eov, input int elat, input bit push);
        exp_t e;
        dividend    = a;
        divisor     = b;
        signed_mode = m;
        start       = 1'b1;
        @(posedge clock);
        #1;
        if (push) begin
            e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.lat = elat; e.t0 = cyc;
            exp_q.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 80; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy && !done) break;
        end
        if (i == 80) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL timeout_%s: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp = n_cmp + 1;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            n_err = n_err + 1;
            $display("FAIL %s: busy=%0b done=%0b q=%h r=%h dz=%0b ov=%0b, required all 0",
                     name, busy, done, quotient, remainder, div_by_zero, overflow);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        clear = 1'b0;
        check_zero("reset_state");

        @(negedge clock);
        issue(-32'sd21, 32'd6, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 1'b0, 35, 1'b1);
        drain("s_neg21_6");
        issue(32'hFFFF_FFEB, 32'd6, 1'b0, 32'h2AAA_AAA7, 32'd1, 1'b0, 1'b0, 35, 1'b1);
        drain("u_big_6");
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 2, 1'b1);
        drain("s_overflow");
        issue(32'd100, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd100, 1'b1, 1'b0, 2, 1'b1);
        drain("div_zero");
        issue(32'd21, -32'sd6, 1'b1, 32'hFFFF_FFFD, 32'd3, 1'b0, 1'b0, 35, 1'b1);
        drain("s_21_neg6");
        issue(-32'sd21, -32'sd6, 1'b1, 32'd3, 32'hFFFF_FFFD, 1'b0, 1'b0, 35, 1'b1);
        drain("s_neg21_neg6");
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 35, 1'b1);
        drain("u_min_ones");

        // Abort mid-iteration: no done may appear, and everything reads back zero.
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 35, 1'b0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check_zero("after_abort");
        clear = 1'b0;
        repeat (40) @(negedge clock);
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 35, 1'b1);
        drain("after_abort_100_7");

        // Start while busy is dropped; start in the done cycle is taken.
        issue(-32'sd21, 32'd6, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 1'b0, 35, 1'b1);
        @(negedge clock);
        issue(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0, 35, 1'b0);
        for (int i = 0; i < 60 && !done; i++) @(negedge clock);
        if (done) begin
            issue(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0, 35, 1'b1);
        end else begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL timeout_busy_start: done=%0b, required 1", done);
        end
        drain("back_to_back");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle restoring integer divider for the CPU datapath. It replaces the single-step combinational DIV path feeding Z high/Z low.
- Operands are latched on a start pulse.
- One quotient bit is produced per clock.
- Quotient (to be written to LO) and remainder (to be written to HI) are presented with a one-cycle done strobe.
- Generalised in operand width and signed/unsigned mode, with explicit divide-by-zero and overflow reporting, which the existing DIV path lacks.

Parameters:
- WIDTH, 32, operand/result width in bits (valid range 4..64).
- SIGNED_DEFAULT, 1, value used for signed_mode when the mode input is tied off by integration.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement divide; 0 = unsigned divide.
- dividend  in  WIDTH  numerator (e.g. contents of Ra).
- divisor  in  WIDTH  denominator (e.g. contents of Rb).
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  single-cycle strobe; results valid from this cycle.
- quotient  out  WIDTH  result for LO; held until the next accepted start.
- remainder  out  WIDTH  result for HI; held until the next accepted start.
- div_by_zero  out  1  sticky with the result; set when divisor == 0.
- overflow  out  1  sticky with the result; set for signed MIN / -1.

Behaviour:
- Reset: clear high at a rising edge forces state IDLE and zeroes busy, done, quotient, remainder, div_by_zero, overflow and all internal registers. Clear during any state aborts the operation; no done is issued.
- States: IDLE -> SETUP -> ITER -> FIXUP -> DONE -> IDLE.
- IDLE:
  - On start=1, latch dividend, divisor and signed_mode, clear the flags, then go to SETUP.
  - start while busy is ignored and is not queued.
- SETUP:
  - If divisor == 0: go to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
  - If signed_mode and dividend == 2^(WIDTH-1) and divisor == all ones: go to DONE with quotient = dividend, remainder = 0, overflow = 1.
  - Otherwise, take magnitudes (when signed), record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign), load the iteration counter with WIDTH-1, and go to ITER.
- ITER, one restoring step per cycle:
  - Shift {partial remainder, magnitude dividend} left by 1.
  - Trial-subtract the divisor magnitude on a WIDTH+1-bit datapath.
  - If the result is non-negative, keep it and shift in quotient bit 1; else shift in 0.
  - Decrement the counter; go to FIXUP after the step where the counter == 0 (exactly WIDTH steps).
- FIXUP: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set; go to DONE.
- DONE: assert done for one cycle, register the outputs, drop busy, return to IDLE.
  - A start in the cycle after DONE is accepted normally.
- Latency from start edge to done:
  - Normal path: WIDTH+3 cycles (35 for WIDTH=32).
  - Divide-by-zero and overflow paths: 2 cycles.
- Semantics: truncation toward zero. The remainder takes the sign of the dividend, and |remainder| < |divisor|.
- In unsigned mode, operands are treated as magnitudes and sign handling is bypassed.
- busy is 1 in SETUP, ITER and FIXUP. done and busy are never both 1.

Decomposition:
- Shared package cpu_div_pkg holds:
  - the state enum (IDLE, SETUP, ITER, FIXUP, DONE);
  - the localparam for the counter width, $clog2(WIDTH);
  - the divide-by-zero quotient constant (all ones).
- One sub-module, div_step: a combinational single restoring step (partial remainder in, divisor in, next partial remainder and quotient bit out). It is parametrised by WIDTH and instantiated once inside ITER.

Test Plan:
- WIDTH=32, signed: dividend=-21, divisor=6, start -> done after 35 cycles; quotient=-3 (0xFFFFFFFD), remainder=-3; flags 0.
- Unsigned: dividend=0xFFFFFFEB, divisor=6 -> quotient=0x2AAAAAA7, remainder=1.
- Signed: dividend=0x80000000, divisor=0xFFFFFFFF -> done after 2 cycles; quotient=0x80000000, remainder=0, overflow=1.
- Divisor=0, dividend=100 -> done after 2 cycles; quotient=0xFFFFFFFF, remainder=100, div_by_zero=1.
- Assert clear at ITER cycle 10 of 100/7 -> no done; all outputs 0 on the next cycle. A fresh start of 100/7 then gives quotient=14, remainder=2.
- Second start pulsed while busy (operands 9/3) is ignored, and the first result (-21/6) is reported. A start in the cycle after done is accepted.
